// File: rtl/addsub_multicycle_if.sv
// addsub_multicycle_if: operand/result handshake bundle for addsub_multicycle
//   master : drives in_valid, x, y, sub, cin, out_ready; samples in_ready and the result group
//   slave  : the adder; drives in_ready, out_valid, out, carry_out, overflow, zero, negative
interface addsub_multicycle_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             negative;
    modport master (
        output in_valid, x, y, sub, cin, out_ready,
        input  in_ready, out_valid, out, carry_out, overflow, zero, negative
    );
    modport slave (
        input  in_valid, x, y, sub, cin, out_ready,
        output in_ready, out_valid, out, carry_out, overflow, zero, negative
    );
endinterface

// File: rtl/addsub_multicycle.sv
// addsub_multicycle: WIDTH-bit add/subtract evaluated CHUNK bits per cycle, LSB slice first
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of addsub_multicycle_if (operand handshake in, result handshake out)
module addsub_multicycle #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    addsub_multicycle_if.slave  bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = NCH > 1 ? $clog2(NCH) : 1;

    if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_param
        $error("WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_carry_out;
    logic             r_overflow;
    logic             r_zero;
    logic             r_negative;

    logic [CHUNK:0]         w_slice;
    logic [WIDTH+CHUNK-1:0] w_cat;
    logic [WIDTH-1:0]       w_res;
    logic                   w_msb_cin;
    logic                   w_last;

    // Operands shift right each cycle so the active slice is always the low CHUNK bits.
    assign w_slice   = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
    // Carry into the slice MSB recovered from the sum bit; on the final slice this is the carry into bit WIDTH-1.
    assign w_msb_cin = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_slice[CHUNK-1];
    // Result fills from the top: new slice enters at the MSB end, older slices move down.
    assign w_cat     = {w_slice[CHUNK-1:0], r_res};
    assign w_res     = w_cat[WIDTH+CHUNK-1:CHUNK];
    assign w_last    = r_cnt == CW'(NCH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
            r_negative  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_a        <= bus.x;
                    r_b        <= bus.sub ? ~bus.y : bus.y;
                    r_carry    <= bus.cin;
                    r_in_ready <= 1'b0;
                    r_state    <= RUN;
                end
                RUN: begin
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_carry <= w_slice[CHUNK];
                    r_res   <= w_res;
                    if (w_last) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_carry_out <= w_slice[CHUNK];
                        r_overflow  <= w_msb_cin ^ w_slice[CHUNK];
                        r_zero      <= w_res == '0;
                        r_negative  <= w_res[WIDTH-1];
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: if (bus.out_ready) begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_cnt       <= '0;
                    r_carry     <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_res;
    assign bus.carry_out = r_carry_out;
    assign bus.overflow  = r_overflow;
    assign bus.zero      = r_zero;
    assign bus.negative  = r_negative;
endmodule

// File: tb/tb_addsub_multicycle.sv
// tb_addsub_multicycle: drives CHUNK=1,4,8,16 instances in lockstep and checks them against an arithmetic model
module tb_addsub_multicycle;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, sub, cin, out_ready;
    logic [15:0] x, y;
    logic        ir[4], ov[4], co[4], ovf[4], zr[4], ng[4];
    logic [15:0] o_out[4];
    int          checks = 0;
    int          errors = 0;
    int          exp_lat[4] = '{16, 4, 2, 1};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gd
        localparam int CH = g == 0 ? 1 : g == 1 ? 4 : g == 2 ? 8 : 16;
        addsub_multicycle_if #(.WIDTH(16)) bus ();
        assign bus.in_valid  = in_valid;
        assign bus.x         = x;
        assign bus.y         = y;
        assign bus.sub       = sub;
        assign bus.cin       = cin;
        assign bus.out_ready = out_ready;
        assign ir[g]    = bus.in_ready;
        assign ov[g]    = bus.out_valid;
        assign o_out[g] = bus.out;
        assign co[g]    = bus.carry_out;
        assign ovf[g]   = bus.overflow;
        assign zr[g]    = bus.zero;
        assign ng[g]    = bus.negative;
        addsub_multicycle #(.WIDTH(16), .CHUNK(CH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c, input int hold);
        logic [15:0] bb, e_out;
        logic [16:0] full;
        logic        e_ovf;
        int          lat[4];
        bb    = s ? ~b : b;
        full  = {1'b0, a} + {1'b0, bb} + {16'd0, c};
        e_out = full[15:0];
        e_ovf = (a[15] == bb[15]) && (e_out[15] != a[15]);
        @(negedge clk);
        for (int d = 0; d < 4; d++) chk($sformatf("c%0d_ready_idle", d), ir[d], 1);
        x = a; y = b; sub = s; cin = c; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; x = 16'($urandom); y = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        for (int d = 0; d < 4; d++) begin
            lat[d] = 0;
            chk($sformatf("c%0d_ready_busy", d), ir[d], 0);
        end
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 4; d++) if (ov[d] && lat[d] == 0) lat[d] = k;
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0 && lat[3] != 0) break;
        end
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("c%0d_latency", d), lat[d], exp_lat[d]);
            chk($sformatf("c%0d_out", d), o_out[d], e_out);
            chk($sformatf("c%0d_carry", d), co[d], full[16]);
            chk($sformatf("c%0d_ovf", d), ovf[d], e_ovf);
            chk($sformatf("c%0d_zero", d), zr[d], e_out == 16'd0);
            chk($sformatf("c%0d_neg", d), ng[d], e_out[15]);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid = 1'b1; x = 16'($urandom); y = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                chk($sformatf("c%0d_hold_valid", d), ov[d], 1);
                chk($sformatf("c%0d_hold_ready", d), ir[d], 0);
                chk($sformatf("c%0d_hold_out", d), {ng[d], zr[d], ovf[d], co[d], o_out[d]},
                    {e_out[15], e_out == 16'd0, e_ovf, full[16], e_out});
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) chk($sformatf("c%0d_after_hs", d), {ov[d], ir[d]}, 2'b01);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic reset_mid_run(input logic [15:0] a, input logic [15:0] b);
        logic seen[4];
        @(negedge clk);
        x = a; y = b; sub = 1'b0; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 4; d++)
            chk($sformatf("c%0d_rst_mid", d), {ir[d], ov[d], co[d], ovf[d], zr[d], ng[d], o_out[d]}, {6'b100000, 16'd0});
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < 4; d++) seen[d] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 4; d++) seen[d] = seen[d] | ov[d];
        end
        for (int d = 0; d < 4; d++) chk($sformatf("c%0d_no_result_after_rst", d), seen[d], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        in_valid = 1'b0; sub = 1'b0; cin = 1'b0; out_ready = 1'b0; x = '0; y = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 4; d++)
            chk($sformatf("c%0d_reset", d), {ir[d], ov[d], co[d], ovf[d], zr[d], ng[d], o_out[d]}, {6'b100000, 16'd0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 0);
        run_op(16'h1234, 16'h4321, 1'b0, 1'b1, 3);
        run_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b1, 0);
        reset_mid_run(16'h7FFF, 16'h0001);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        for (int i = 0; i < 20; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/addsub_multicycle.md
ADDSUB_MULTICYCLE -- requirements
Module: addsub_multicycle

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter CHUNK, default 4, bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, CHUNK >= 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand presented.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 x  input  WIDTH  first operand.
REQ-008 y  input  WIDTH  second operand.
REQ-009 sub  input  1  0 = x+y+cin, 1 = x+~y+cin.
REQ-010 cin  input  1  carry in; for plain subtract cin=1 (borrow convention: carry=1 means no borrow).
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out  output  WIDTH  sum/difference.
REQ-014 carry_out  output  1  carry out of MSB.
REQ-015 overflow  output  1  signed overflow.
REQ-016 zero  output  1  out == 0.
REQ-017 negative  output  1  out[WIDTH-1].

Function
REQ-018 FSM states: IDLE, RUN, DONE; IDLE->RUN on in_valid&&in_ready; RUN->DONE after final chunk; DONE->IDLE on out_valid&&out_ready.
REQ-019 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-020 On acceptance x, y (inverted when sub=1) and cin SHALL be latched; later input changes have no effect on the operation.
REQ-021 In RUN, one CHUNK-bit slice per cycle, LSB slice first; carry between slices held in a register, slice 0 uses latched cin.
REQ-022 Latency: out_valid SHALL assert exactly WIDTH/CHUNK cycles after the accepting edge (CHUNK=WIDTH gives 1 cycle).
REQ-023 Chunk counter SHALL count 0..WIDTH/CHUNK-1 and clear on entry to IDLE.
REQ-024 carry_out = carry out of bit WIDTH-1; overflow = carry into bit WIDTH-1 XOR carry_out; both computed in the final slice.
REQ-025 zero and negative SHALL derive from the full registered result.
REQ-026 out, carry_out, overflow, zero, negative SHALL remain stable throughout DONE regardless of out_ready or inputs.
REQ-027 in_valid during RUN or DONE SHALL be ignored (no queueing); a new acceptance is possible no earlier than the cycle after the DONE handshake.
REQ-028 Result arithmetic SHALL be modulo 2^WIDTH; no saturation.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, counter 0, carry register 0, out 0, carry_out 0, overflow 0, zero 0, negative 0, out_valid 0, in_ready 1 (in_ready follows IDLE once clock-free reset released).
REQ-030 Reset asserted mid-RUN or in DONE SHALL abandon the operation; no result is presented after release.

Verification (WIDTH=16, CHUNK=4)
REQ-031 x=0x7FFF, y=0x0001, sub=0, cin=0 -> out_valid 4 cycles after accept, out=0x8000, carry_out=0, overflow=1, negative=1, zero=0.
REQ-032 x=0xFFFF, y=0x0001, sub=0, cin=0 -> out=0x0000, carry_out=1, overflow=0, zero=1.
REQ-033 x=0x0005, y=0x0007, sub=1, cin=1 -> out=0xFFFE, carry_out=0, overflow=0, negative=1; x=0x8000, y=0x0001, sub=1, cin=1 -> out=0x7FFF, carry_out=1, overflow=1.
REQ-034 out_ready held 0 for 3 cycles in DONE while in_valid=1 with new operands -> outputs unchanged, in_ready=0, second operation accepted only after handshake, its result correct.
REQ-035 rst_n pulsed low during cycle 2 of RUN -> all outputs zero, out_valid never asserts for that operation, next operation completes normally in 4 cycles.
REQ-036 Re-run REQ-031..033 with CHUNK=1, 8, 16 -> identical results, latency 16, 2, 1 cycles.
